// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_stall_ctrl
// Brief    : Stall/flush sequencer for a 5-stage pipeline. Merges per-stage
//            hazard requests into a stall vector, tracks data-RAM wait state,
//            defers exception flushes behind in-flight data accesses and runs
//            an acknowledge watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inst_wait,
  input  logic                 load_related,
  input  logic                 ex_busy,
  input  logic                 mem_req,
  input  logic                 mem_ack,
  input  logic                 exc_flush,
  output logic [5:0]           stall,
  output logic                 flush,
  output logic                 mem_busy,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] wait_cnt
);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT       = 2'd1,
    S_FLUSH_WAIT = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_TIMEOUT = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] C_ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  // Stall patterns: a stalled stage also holds every stage upstream of it.
  localparam logic [5:0] C_STALL_MEM = 6'b011111;
  localparam logic [5:0] C_STALL_EX  = 6'b001111;
  localparam logic [5:0] C_STALL_ID  = 6'b000111;
  localparam logic [5:0] C_STALL_IF  = 6'b000011;

  state_t               r_state;
  state_t               w_next_state;
  logic [CNT_WIDTH-1:0] r_wait_cnt;
  logic [CNT_WIDTH-1:0] w_next_cnt;
  logic                 w_mem_wait;
  logic                 w_flush_req;
  logic                 w_timeout;

  // State and wait-counter registers; FLUSH_WAIT doubles as the pending-flush flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_cnt;
    end
  end

  // Next-state, counter and internal request decode.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = '0;
    w_mem_wait   = 1'b0;
    w_flush_req  = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (mem_req && !mem_ack) begin
          // Access not satisfied this cycle: stall MEM now, a flush has to wait.
          w_mem_wait   = 1'b1;
          w_next_cnt   = C_ONE;
          w_next_state = exc_flush ? S_FLUSH_WAIT : S_WAIT;
        end else begin
          w_flush_req = exc_flush;
        end
      end
      S_WAIT, S_FLUSH_WAIT: begin
        if (mem_ack) begin
          w_next_state = S_IDLE;
          w_flush_req  = exc_flush || (r_state == S_FLUSH_WAIT);
        end else if (r_wait_cnt >= C_TIMEOUT) begin
          // Watchdog expiry releases the pipeline; a deferred flush still fires.
          w_timeout    = 1'b1;
          w_next_state = S_IDLE;
          w_flush_req  = exc_flush || (r_state == S_FLUSH_WAIT);
        end else begin
          w_mem_wait = 1'b1;
          w_next_cnt = r_wait_cnt + 1'b1;
          if (exc_flush) begin
            w_next_state = S_FLUSH_WAIT;
          end
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Output decode: reset masks everything, a flush overrides any stall.
  always_comb begin
    stall     = 6'b000000;
    flush     = 1'b0;
    mem_busy  = 1'b0;
    bus_error = 1'b0;
    if (!rst) begin
      flush     = w_flush_req;
      bus_error = w_timeout;
      mem_busy  = (r_state != S_IDLE);
      if (!w_flush_req) begin
        if (w_mem_wait) begin
          stall = C_STALL_MEM;
        end else if (ex_busy) begin
          stall = C_STALL_EX;
        end else if (load_related) begin
          stall = C_STALL_ID;
        end else if (inst_wait) begin
          stall = C_STALL_IF;
        end
      end
    end
  end

  assign wait_cnt = r_wait_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_stall_ctrl
// Brief    : Directed self-checking bench for pipeline_stall_ctrl. Two
//            instances share stimulus: one with the default watchdog, one
//            with TIMEOUT=4 for the watchdog scenarios.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

  logic clk = 1'b0;
  logic rst, inst_wait, load_related, ex_busy, mem_req, mem_ack, exc_flush;

  logic [5:0] stall_a, stall_b;
  logic       flush_a, flush_b, busy_a, busy_b, berr_a, berr_b;
  logic [7:0] cnt_a, cnt_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       sel;   // 0: default-timeout DUT, 1: TIMEOUT=4 DUT
    logic [5:0] stall;
    logic       flush;
    logic       busy;
    logic       berr;
    logic [7:0] cnt;
    string      tag;
  } exp_t;

  exp_t sb[$];

  pipeline_stall_ctrl #(.TIMEOUT(255), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .inst_wait(inst_wait), .load_related(load_related),
    .ex_busy(ex_busy), .mem_req(mem_req), .mem_ack(mem_ack), .exc_flush(exc_flush),
    .stall(stall_a), .flush(flush_a), .mem_busy(busy_a), .bus_error(berr_a),
    .wait_cnt(cnt_a)
  );

  pipeline_stall_ctrl #(.TIMEOUT(4), .CNT_WIDTH(8)) dut_to (
    .clk(clk), .rst(rst), .inst_wait(inst_wait), .load_related(load_related),
    .ex_busy(ex_busy), .mem_req(mem_req), .mem_ack(mem_ack), .exc_flush(exc_flush),
    .stall(stall_b), .flush(flush_b), .mem_busy(busy_b), .bus_error(berr_b),
    .wait_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the expected outputs, compare at negedge.
  task automatic step(input logic r, input logic mr, input logic ma, input logic ef,
                      input logic eb, input logic lr, input logic iw, input logic sel,
                      input logic [5:0] es, input logic efl, input logic ebusy,
                      input logic eberr, input logic [7:0] ecnt, input string tag);
    exp_t e;
    exp_t got;
    rst = r; mem_req = mr; mem_ack = ma; exc_flush = ef;
    ex_busy = eb; load_related = lr; inst_wait = iw;
    e.sel = sel; e.stall = es; e.flush = efl; e.busy = ebusy;
    e.berr = eberr; e.cnt = ecnt; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    if (got.sel) begin
      check({got.tag, ".stall"}, 32'(stall_b), 32'(got.stall));
      check({got.tag, ".flush"}, 32'(flush_b), 32'(got.flush));
      check({got.tag, ".busy"},  32'(busy_b),  32'(got.busy));
      check({got.tag, ".berr"},  32'(berr_b),  32'(got.berr));
      check({got.tag, ".cnt"},   32'(cnt_b),   32'(got.cnt));
    end else begin
      check({got.tag, ".stall"}, 32'(stall_a), 32'(got.stall));
      check({got.tag, ".flush"}, 32'(flush_a), 32'(got.flush));
      check({got.tag, ".busy"},  32'(busy_a),  32'(got.busy));
      check({got.tag, ".berr"},  32'(berr_a),  32'(got.berr));
      check({got.tag, ".cnt"},   32'(cnt_a),   32'(got.cnt));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; mem_req = 1'b1; mem_ack = 1'b0; exc_flush = 1'b0;
    ex_busy = 1'b1; load_related = 1'b0; inst_wait = 1'b0;
    @(posedge clk);
    #1;

    //   rst mr ma ef eb lr iw sel stall      fl bsy ber cnt
    // Reset holds every output low despite active requests.
    step(1, 1, 0, 0, 1, 0, 0, 0, 6'b000000, 0, 0, 0, 8'd0, "rst0");
    step(1, 1, 0, 0, 1, 0, 0, 0, 6'b000000, 0, 0, 0, 8'd0, "rst1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 8'd0, "idle");

    // Zero-wait access.
    step(0, 1, 1, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 8'd0, "zw");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 8'd0, "zw_after");

    // Three-cycle access.
    step(0, 1, 0, 0, 0, 0, 0, 0, 6'b011111, 0, 0, 0, 8'd0, "acc3_c0");
    step(0, 1, 0, 0, 0, 0, 0, 0, 6'b011111, 0, 1, 0, 8'd1, "acc3_c1");
    step(0, 1, 0, 0, 0, 0, 0, 0, 6'b011111, 0, 1, 0, 8'd2, "acc3_c2");
    step(0, 1, 1, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 0, 8'd3, "acc3_c3");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 8'd0, "acc3_c4");

    // Priority of hazard sources.
    step(0, 0, 0, 0, 1, 1, 0, 0, 6'b001111, 0, 0, 0, 8'd0, "pri_ex");
    step(0, 0, 0, 0, 0, 1, 0, 0, 6'b000111, 0, 0, 0, 8'd0, "pri_ld");
    step(0, 0, 0, 0, 0, 0, 1, 0, 6'b000011, 0, 0, 0, 8'd0, "pri_if");
    step(0, 1, 0, 0, 1, 1, 1, 0, 6'b011111, 0, 0, 0, 8'd0, "pri_mem");
    step(0, 0, 1, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 0, 8'd1, "pri_mem_ack");

    // Immediate flushes from IDLE override stalls.
    step(0, 0, 0, 1, 1, 0, 0, 0, 6'b000000, 1, 0, 0, 8'd0, "flush_idle");
    step(0, 1, 1, 1, 0, 0, 0, 0, 6'b000000, 1, 0, 0, 8'd0, "flush_zw");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 8'd0, "flush_after");

    // Deferred flush behind a five-cycle access; second pulse absorbed.
    step(0, 1, 0, 0, 0, 0, 0, 0, 6'b011111, 0, 0, 0, 8'd0, "dfl_c0");
    step(0, 1, 0, 0, 0, 0, 0, 0, 6'b011111, 0, 1, 0, 8'd1, "dfl_c1");
    step(0, 1, 0, 1, 0, 0, 0, 0, 6'b011111, 0, 1, 0, 8'd2, "dfl_c2");
    step(0, 1, 0, 1, 0, 0, 0, 0, 6'b011111, 0, 1, 0, 8'd3, "dfl_c3");
    step(0, 1, 0, 0, 0, 0, 0, 0, 6'b011111, 0, 1, 0, 8'd4, "dfl_c4");
    step(0, 1, 1, 0, 0, 0, 0, 0, 6'b000000, 1, 1, 0, 8'd5, "dfl_c5");
    step(0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 8'd0, "dfl_c6");

    // Watchdog on the TIMEOUT=4 instance, starting from a clean reset.
    step(1, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 8'd0, "to_rst");
    step(0, 1, 0, 0, 0, 0, 0, 1, 6'b011111, 0, 0, 0, 8'd0, "to_c0");
    step(0, 1, 0, 0, 0, 0, 0, 1, 6'b011111, 0, 1, 0, 8'd1, "to_c1");
    step(0, 1, 0, 0, 0, 0, 0, 1, 6'b011111, 0, 1, 0, 8'd2, "to_c2");
    step(0, 1, 0, 0, 0, 0, 0, 1, 6'b011111, 0, 1, 0, 8'd3, "to_c3");
    step(0, 1, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 1, 1, 8'd4, "to_c4");
    step(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 8'd0, "to_c5");

    // Reset in the middle of a wait: no bus error, IDLE on the next edge.
    step(0, 1, 0, 0, 0, 0, 0, 1, 6'b011111, 0, 0, 0, 8'd0, "rw_c0");
    step(0, 1, 0, 0, 0, 0, 0, 1, 6'b011111, 0, 1, 0, 8'd1, "rw_c1");
    step(1, 1, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 8'd2, "rw_c2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 8'd0, "rw_c3");
    step(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 8'd0, "rw_c4");
    step(0, 0, 0, 0, 0, 0, 0, 1, 6'b000000, 0, 0, 0, 8'd0, "rw_c5");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
